// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'd0,
    SEL_BR   = 2'd1,
    SEL_JALR = 2'd2,
    SEL_TRAP = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_target_sel.sv
// Branch/jump target adder, priority next-pc mux and misaligned-target check.
module pc_target_sel
  import pc_pkg::*;
#(
  parameter int unsigned      DBITS   = 32,
  parameter logic [DBITS-1:0] TRAP_PC = 'h20
) (
  input  logic [DBITS-1:0] i_pc_plus4,
  input  logic [DBITS-1:0] i_imm,
  input  logic [DBITS-1:0] i_alu_out,
  input  logic             i_is_branch,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic             i_comp_true,
  output logic [DBITS-1:0] o_next_pc,
  output pc_sel_e          o_sel,
  output logic             o_taken,
  output logic             o_trap
);

  logic [DBITS-1:0] w_br_tgt;
  logic [DBITS-1:0] w_tgt;

  assign w_br_tgt = i_pc_plus4 + (i_imm << 2);

  // jalr outranks jal, which outranks a taken conditional branch
  always_comb begin
    o_taken = 1'b0;
    o_sel   = SEL_SEQ;
    w_tgt   = i_pc_plus4;
    if (i_is_jalr) begin
      o_taken = 1'b1;
      o_sel   = SEL_JALR;
      w_tgt   = i_alu_out;
    end else if (i_is_jal || (i_is_branch && i_comp_true)) begin
      o_taken = 1'b1;
      o_sel   = SEL_BR;
      w_tgt   = w_br_tgt;
    end
    o_trap = o_taken && (w_tgt[1:0] != 2'b00);
    if (o_trap) begin
      o_sel = SEL_TRAP;
    end
  end

  always_comb begin
    o_next_pc = i_pc_plus4;
    case (o_sel)
      SEL_SEQ:  o_next_pc = i_pc_plus4;
      SEL_BR:   o_next_pc = w_br_tgt;
      SEL_JALR: o_next_pc = i_alu_out;
      SEL_TRAP: o_next_pc = TRAP_PC;
      default:  o_next_pc = i_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC stage: boot/run/halt FSM, pc register, redirect/trap flags and retired counter.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int unsigned      DBITS    = 32,
  parameter logic [DBITS-1:0] RESET_PC = 'h40,
  parameter logic [DBITS-1:0] TRAP_PC  = 'h20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [DBITS-1:0] imm,
  input  logic             comp_true,
  input  logic [DBITS-1:0] alu_out,
  output logic [DBITS-1:0] pc,
  output logic [DBITS-1:0] pc_plus4,
  output logic             redirect,
  output logic             trap,
  output logic             running,
  output logic [DBITS-1:0] instret
);

  pc_state_e        r_state;
  pc_state_e        w_state_nxt;
  logic [DBITS-1:0] r_pc;
  logic [DBITS-1:0] w_pc_nxt;
  logic             r_redirect;
  logic             w_redirect_nxt;
  logic             r_trap;
  logic             w_trap_nxt;
  logic [DBITS-1:0] r_instret;
  logic [DBITS-1:0] w_instret_nxt;

  logic [DBITS-1:0] w_pc_plus4;
  logic [DBITS-1:0] w_sel_pc;
  pc_sel_e          w_sel;
  logic             w_taken;
  logic             w_trap;

  assign w_pc_plus4 = r_pc + DBITS'(PC_INC);

  pc_target_sel #(
    .DBITS   (DBITS),
    .TRAP_PC (TRAP_PC)
  ) u_target_sel (
    .i_pc_plus4  (w_pc_plus4),
    .i_imm       (imm),
    .i_alu_out   (alu_out),
    .i_is_branch (is_branch),
    .i_is_jal    (is_jal),
    .i_is_jalr   (is_jalr),
    .i_comp_true (comp_true),
    .o_next_pc   (w_sel_pc),
    .o_sel       (w_sel),
    .o_taken     (w_taken),
    .o_trap      (w_trap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_redirect <= 1'b0;
      r_trap     <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redirect <= w_redirect_nxt;
      r_trap     <= w_trap_nxt;
      r_instret  <= w_instret_nxt;
    end
  end

  // Halt wins over any control flow presented with it: pc stays on the halt itself
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_redirect_nxt = 1'b0;
    w_trap_nxt     = 1'b0;
    w_instret_nxt  = r_instret;
    case (r_state)
      BOOT: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          w_instret_nxt = r_instret + DBITS'(1);
          if (halt) begin
            w_state_nxt = HALTED;
          end else begin
            w_pc_nxt       = w_sel_pc;
            w_redirect_nxt = w_taken;
            w_trap_nxt     = w_trap && (w_sel == SEL_TRAP);
          end
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = BOOT;
      end
    endcase
  end

  assign pc       = r_pc;
  assign pc_plus4 = w_pc_plus4;
  assign redirect = r_redirect;
  assign trap     = r_trap;
  assign running  = (r_state == RUN);
  assign instret  = r_instret;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit.
module tb_pc_next_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        halt;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [31:0] imm;
  logic        comp_true;
  logic [31:0] alu_out;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        trap;
  logic        running;
  logic [31:0] instret;

  logic        s_reset_n;
  logic [7:0]  s_pc;
  logic [7:0]  s_pc_plus4;
  logic        s_redirect;
  logic        s_trap;
  logic        s_running;
  logic [7:0]  s_instret;

  int checks = 0;
  int passed = 0;

  pc_next_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .halt      (halt),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .imm       (imm),
    .comp_true (comp_true),
    .alu_out   (alu_out),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .trap      (trap),
    .running   (running),
    .instret   (instret)
  );

  // Narrow instance so the retired counter wrap is reachable in a few hundred cycles
  pc_next_unit #(
    .DBITS    (8),
    .RESET_PC (8'h40),
    .TRAP_PC  (8'h20)
  ) dut_small (
    .clk       (clk),
    .reset_n   (s_reset_n),
    .stall     (1'b0),
    .halt      (1'b0),
    .is_branch (1'b0),
    .is_jal    (1'b0),
    .is_jalr   (1'b0),
    .imm       (8'h00),
    .comp_true (1'b0),
    .alu_out   (8'h00),
    .pc        (s_pc),
    .pc_plus4  (s_pc_plus4),
    .redirect  (s_redirect),
    .trap      (s_trap),
    .running   (s_running),
    .instret   (s_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall     = 1'b0;
    halt      = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    imm       = 32'h0;
    comp_true = 1'b0;
    alu_out   = 32'h0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset_n   = 1'b0;
    s_reset_n = 1'b0;
    step();
    step();
    checks++; if (pc !== 32'h40) $display("FAIL reset_pc got=%h exp=%h", pc, 32'h40); else passed++;
    checks++; if (instret !== 32'h0) $display("FAIL reset_instret got=%h exp=0", instret); else passed++;
    checks++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else passed++;
    checks++; if (redirect !== 1'b0 || trap !== 1'b0)
      $display("FAIL reset_flags got=%b%b exp=00", redirect, trap); else passed++;
    checks++; if (pc_plus4 !== 32'h44) $display("FAIL boot_pc_plus4 got=%h exp=44", pc_plus4); else passed++;
    reset_n = 1'b1;
    step();
    checks++; if (running !== 1'b1) $display("FAIL boot_to_run got=%b exp=1", running); else passed++;
    checks++; if (pc !== 32'h40 || instret !== 32'h0)
      $display("FAIL boot_hold got pc=%h ir=%h exp pc=40 ir=0", pc, instret); else passed++;
    step(); step(); step();
    checks++; if (pc !== 32'h4C) $display("FAIL seq_pc got=%h exp=4c", pc); else passed++;
    checks++; if (instret !== 32'd3) $display("FAIL seq_instret got=%0d exp=3", instret); else passed++;
    step();
  endtask

  task automatic test_branch();
    checks++; if (pc !== 32'h50) $display("FAIL branch_start got=%h exp=50", pc); else passed++;
    is_branch = 1'b1; comp_true = 1'b1; imm = 32'hFFFF_FFFE;
    step();
    checks++; if (pc !== 32'h4C || redirect !== 1'b1)
      $display("FAIL branch_taken got pc=%h rd=%b exp pc=4c rd=1", pc, redirect); else passed++;
    clear_ctrl();
    step();
    checks++; if (pc !== 32'h50 || redirect !== 1'b0)
      $display("FAIL redirect_one_cycle got pc=%h rd=%b exp pc=50 rd=0", pc, redirect); else passed++;
    is_branch = 1'b1; comp_true = 1'b0; imm = 32'hFFFF_FFFE;
    step();
    checks++; if (pc !== 32'h54 || redirect !== 1'b0)
      $display("FAIL branch_not_taken got pc=%h rd=%b exp pc=54 rd=0", pc, redirect); else passed++;
    checks++; if (instret !== 32'd7) $display("FAIL branch_instret got=%0d exp=7", instret); else passed++;
    clear_ctrl();
  endtask

  task automatic test_jalr_trap();
    is_jalr = 1'b1; is_jal = 1'b1; imm = 32'h10; alu_out = 32'h100;
    step();
    checks++; if (pc !== 32'h100 || redirect !== 1'b1 || trap !== 1'b0)
      $display("FAIL jalr_priority got pc=%h rd=%b tr=%b exp pc=100 rd=1 tr=0", pc, redirect, trap); else passed++;
    is_jal = 1'b0; alu_out = 32'h102;
    step();
    checks++; if (pc !== 32'h20 || trap !== 1'b1 || redirect !== 1'b1)
      $display("FAIL misaligned_trap got pc=%h rd=%b tr=%b exp pc=20 rd=1 tr=1", pc, redirect, trap); else passed++;
    checks++; if (instret !== 32'd9) $display("FAIL trap_instret got=%0d exp=9", instret); else passed++;
    clear_ctrl();
    step();
    checks++; if (pc !== 32'h24 || trap !== 1'b0 || redirect !== 1'b0)
      $display("FAIL trap_clear got pc=%h rd=%b tr=%b exp pc=24 rd=0 tr=0", pc, redirect, trap); else passed++;
  endtask

  task automatic test_stall();
    is_jal = 1'b1; imm = 32'h4;
    step();
    checks++; if (pc !== 32'h38 || redirect !== 1'b1)
      $display("FAIL jal_taken got pc=%h rd=%b exp pc=38 rd=1", pc, redirect); else passed++;
    stall = 1'b1; halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h38 || instret !== 32'd11 || redirect !== 1'b0 || running !== 1'b1)
        $display("FAIL stall_hold[%0d] got pc=%h ir=%0d rd=%b run=%b exp pc=38 ir=11 rd=0 run=1",
                 i, pc, instret, redirect, running); else passed++;
    end
    stall = 1'b0; halt = 1'b0;
    step();
    checks++; if (pc !== 32'h4C || redirect !== 1'b1 || instret !== 32'd12)
      $display("FAIL stall_release got pc=%h rd=%b ir=%0d exp pc=4c rd=1 ir=12", pc, redirect, instret); else passed++;
    imm = 32'h4;
    step();
    checks++; if (pc !== 32'h60) $display("FAIL jal_to_60 got=%h exp=60", pc); else passed++;
    clear_ctrl();
  endtask

  task automatic test_halt_reset();
    halt = 1'b1; is_jal = 1'b1; imm = 32'h8;
    step();
    checks++; if (pc !== 32'h60 || running !== 1'b0 || instret !== 32'd14 || redirect !== 1'b0)
      $display("FAIL halt_enter got pc=%h run=%b ir=%0d rd=%b exp pc=60 run=0 ir=14 rd=0",
               pc, running, instret, redirect); else passed++;
    clear_ctrl();
    is_jal = 1'b1; imm = 32'h8;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (pc !== 32'h60 || instret !== 32'd14 || running !== 1'b0 || pc_plus4 !== 32'h64)
        $display("FAIL halt_frozen[%0d] got pc=%h ir=%0d run=%b p4=%h exp pc=60 ir=14 run=0 p4=64",
                 i, pc, instret, running, pc_plus4); else passed++;
    end
    clear_ctrl();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h40 || instret !== 32'h0 || running !== 1'b0)
      $display("FAIL async_reset got pc=%h ir=%h run=%b exp pc=40 ir=0 run=0", pc, instret, running); else passed++;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_wrap();
    is_jalr = 1'b1; alu_out = 32'hFFFF_FFFC;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL jalr_top got=%h exp=fffffffc", pc); else passed++;
    checks++; if (pc_plus4 !== 32'h0) $display("FAIL pc_plus4_wrap got=%h exp=0", pc_plus4); else passed++;
    clear_ctrl();
    step();
    checks++; if (pc !== 32'h0 || redirect !== 1'b0)
      $display("FAIL pc_wrap got pc=%h rd=%b exp pc=0 rd=0", pc, redirect); else passed++;
    s_reset_n = 1'b1;
    step();
    for (int i = 0; i < 255; i++) step();
    checks++; if (s_instret !== 8'hFF) $display("FAIL instret_max got=%h exp=ff", s_instret); else passed++;
    step();
    checks++; if (s_instret !== 8'h00 || s_pc !== 8'h40)
      $display("FAIL instret_wrap got ir=%h pc=%h exp ir=00 pc=40", s_instret, s_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr_trap();
    test_stall();
    test_halt_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
